// File: rtl/mem_wb_forward_source.sv
// EX/MEM and MEM/WB pipeline registers: data-memory port, write-back select, forwarding sources and stall.
// Optional macro JAL_LINK_EN keeps PC+4 in EX/MEM so MemtoReg=10 writes back PC+8.
module mem_wb_forward_source #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] ForwardB_out,
  input  logic [DATA_W-1:0] PCAddResult2,
  input  logic [REG_W-1:0]  EXRTorRD,
  input  logic              RegWrite1,
  input  logic              MemRead1,
  input  logic              MemWrite1,
  input  logic [1:0]        MemtoReg1,
  input  logic              Flush,
  input  logic [REG_W-1:0]  IFIDRs,
  input  logic [REG_W-1:0]  IFIDRt,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic              MemReady,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemRd,
  output logic              MemWr,
  output logic [REG_W-1:0]  EXMEMRd,
  output logic              EXMEMRegWrite,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [REG_W-1:0]  MEMWBRd,
  output logic              MEMWBRegWrite,
  output logic [DATA_W-1:0] WriteData,
  output logic              PipeStall
);

  typedef enum logic {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_e;

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] exmem_alu_q, exmem_alu_d;
  logic [DATA_W-1:0] exmem_store_q, exmem_store_d;
  logic [REG_W-1:0]  exmem_rd_q, exmem_rd_d;
  logic              exmem_regwrite_q, exmem_regwrite_d;
  logic              exmem_memread_q, exmem_memread_d;
  logic              exmem_memwrite_q, exmem_memwrite_d;
  logic [1:0]        exmem_memtoreg_q, exmem_memtoreg_d;
  logic [REG_W-1:0]  memwb_rd_q, memwb_rd_d;
  logic              memwb_regwrite_q, memwb_regwrite_d;
  logic [DATA_W-1:0] memwb_data_q, memwb_data_d;
`ifdef JAL_LINK_EN
  logic [DATA_W-1:0] exmem_pc_q, exmem_pc_d;
`else
  logic unused_pc;
  assign unused_pc = ^PCAddResult2;
`endif

  logic              mem_pending;
  logic              mem_stall;
  logic              load_use;
  logic [DATA_W-1:0] wb_value;

  // A pending access that is not completing this cycle freezes EX/MEM and bubbles MEM/WB.
  always_comb begin
    mem_pending = (state_q == MEM_WAIT) | exmem_memread_q | exmem_memwrite_q;
    mem_stall   = mem_pending & ~MemReady;
    load_use    = MemRead1 & RegWrite1 & (EXRTorRD != '0) &
                  ((EXRTorRD == IFIDRs) | (EXRTorRD == IFIDRt));
    state_d     = mem_stall ? MEM_WAIT : MEM_IDLE;
  end

  always_comb begin
    case (exmem_memtoreg_q)
      2'b01:   wb_value = MemReadData;
`ifdef JAL_LINK_EN
      2'b10:   wb_value = exmem_pc_q + DATA_W'(4);
`else
      2'b10:   wb_value = exmem_alu_q;
`endif
      default: wb_value = exmem_alu_q;
    endcase
  end

  // Memory wait dominates: a held EX/MEM ignores both Flush and the load-use bubble.
  always_comb begin
    exmem_alu_d      = exmem_alu_q;
    exmem_store_d    = exmem_store_q;
    exmem_rd_d       = exmem_rd_q;
    exmem_regwrite_d = exmem_regwrite_q;
    exmem_memread_d  = exmem_memread_q;
    exmem_memwrite_d = exmem_memwrite_q;
    exmem_memtoreg_d = exmem_memtoreg_q;
`ifdef JAL_LINK_EN
    exmem_pc_d       = exmem_pc_q;
`endif
    if (!mem_stall) begin
      if (Flush | load_use) begin
        exmem_alu_d      = '0;
        exmem_store_d    = '0;
        exmem_rd_d       = '0;
        exmem_regwrite_d = 1'b0;
        exmem_memread_d  = 1'b0;
        exmem_memwrite_d = 1'b0;
        exmem_memtoreg_d = 2'b00;
`ifdef JAL_LINK_EN
        exmem_pc_d       = '0;
`endif
      end else begin
        exmem_alu_d      = ALUResult_in;
        exmem_store_d    = ForwardB_out;
        exmem_rd_d       = EXRTorRD;
        exmem_regwrite_d = RegWrite1 & (EXRTorRD != '0);
        exmem_memread_d  = MemRead1;
        exmem_memwrite_d = MemWrite1;
        exmem_memtoreg_d = MemtoReg1;
`ifdef JAL_LINK_EN
        exmem_pc_d       = PCAddResult2;
`endif
      end
    end
  end

  always_comb begin
    if (mem_stall) begin
      memwb_rd_d       = '0;
      memwb_regwrite_d = 1'b0;
      memwb_data_d     = '0;
    end else begin
      memwb_rd_d       = exmem_rd_q;
      memwb_regwrite_d = exmem_regwrite_q;
      memwb_data_d     = wb_value;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= MEM_IDLE;
      exmem_alu_q      <= '0;
      exmem_store_q    <= '0;
      exmem_rd_q       <= '0;
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 2'b00;
`ifdef JAL_LINK_EN
      exmem_pc_q       <= '0;
`endif
      memwb_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_data_q     <= '0;
    end else begin
      state_q          <= state_d;
      exmem_alu_q      <= exmem_alu_d;
      exmem_store_q    <= exmem_store_d;
      exmem_rd_q       <= exmem_rd_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_memread_q  <= exmem_memread_d;
      exmem_memwrite_q <= exmem_memwrite_d;
      exmem_memtoreg_q <= exmem_memtoreg_d;
`ifdef JAL_LINK_EN
      exmem_pc_q       <= exmem_pc_d;
`endif
      memwb_rd_q       <= memwb_rd_d;
      memwb_regwrite_q <= memwb_regwrite_d;
      memwb_data_q     <= memwb_data_d;
    end
  end

  assign MemAddr       = exmem_alu_q;
  assign MemWData      = exmem_store_q;
  assign MemRd         = exmem_memread_q;
  assign MemWr         = exmem_memwrite_q;
  assign EXMEMRd       = exmem_rd_q;
  assign EXMEMRegWrite = exmem_regwrite_q;
  assign ALUResult_out = exmem_alu_q;
  assign MEMWBRd       = memwb_rd_q;
  assign MEMWBRegWrite = memwb_regwrite_q;
  assign WriteData     = memwb_data_q;
  assign PipeStall     = mem_stall | load_use;

endmodule

// File: tb/tb_mem_wb_forward_source.sv
// Self-checking bench for mem_wb_forward_source: vector table, directed corner sequences, random vs. model.
// Expectations follow JAL_LINK_EN when the bench is built with that macro.
module tb_mem_wb_forward_source;

`ifdef JAL_LINK_EN
  localparam bit LinkEn = 1'b1;
`else
  localparam bit LinkEn = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResult_in, ForwardB_out, PCAddResult2, MemReadData;
  logic [4:0]  EXRTorRD, IFIDRs, IFIDRt;
  logic        RegWrite1, MemRead1, MemWrite1, Flush, MemReady;
  logic [1:0]  MemtoReg1;
  logic [31:0] MemAddr, MemWData, ALUResult_out, WriteData;
  logic        MemRd, MemWr, EXMEMRegWrite, MEMWBRegWrite, PipeStall;
  logic [4:0]  EXMEMRd, MEMWBRd;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 Clk = ~Clk;

  mem_wb_forward_source dut (
    .Clk(Clk), .Reset(Reset), .ALUResult_in(ALUResult_in), .ForwardB_out(ForwardB_out),
    .PCAddResult2(PCAddResult2), .EXRTorRD(EXRTorRD), .RegWrite1(RegWrite1),
    .MemRead1(MemRead1), .MemWrite1(MemWrite1), .MemtoReg1(MemtoReg1), .Flush(Flush),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .MemReadData(MemReadData), .MemReady(MemReady),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRd(MemRd), .MemWr(MemWr),
    .EXMEMRd(EXMEMRd), .EXMEMRegWrite(EXMEMRegWrite), .ALUResult_out(ALUResult_out),
    .MEMWBRd(MEMWBRd), .MEMWBRegWrite(MEMWBRegWrite), .WriteData(WriteData),
    .PipeStall(PipeStall)
  );

  typedef struct packed {
    logic [31:0] alu, store, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [1:0]  mtr;
  } ex_t;

  typedef struct {
    string       name;
    ex_t         in;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_memrd, exp_memwr, exp_wb_rw;
    logic [31:0] exp_wd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_ex(input ex_t e);
    ALUResult_in = e.alu;  ForwardB_out = e.store; PCAddResult2 = e.pc;
    EXRTorRD = e.rd;       RegWrite1 = e.rw;       MemRead1 = e.mr;
    MemWrite1 = e.mw;      MemtoReg1 = e.mtr;
  endtask

  task automatic drive_nop();
    drive_ex('0);
    Flush = 1'b0; IFIDRs = '0; IFIDRt = '0; MemReady = 1'b1;
  endtask

  function automatic ex_t mk(input logic [31:0] alu, input logic [31:0] store, input logic [31:0] pc,
                             input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                             input logic [1:0] mtr);
    mk = '{alu: alu, store: store, pc: pc, rd: rd, rw: rw, mr: mr, mw: mw, mtr: mtr};
  endfunction

  // Reference write-back rule taken straight from the MemtoReg encoding.
  function automatic logic [31:0] ref_wb(input ex_t e, input logic [31:0] rdata);
    if (e.mtr == 2'b01) return rdata;
    if (e.mtr == 2'b10 && LinkEn) return e.pc + 32'd4;
    return e.alu;
  endfunction

  vec_t vecs[7];
  ex_t  m_ex, nxt;
  logic [4:0]  m_wb_rd;
  logic        m_wb_rw, hold, lu;
  logic [31:0] m_wb_val;

  initial begin
    vecs[0] = '{"alu_op",  mk(32'h0000_00AA, 32'h0, 32'h0, 5'd3, 1, 0, 0, 2'b00), 5'd3, 1, 0, 0, 1, 32'h0000_00AA};
    vecs[1] = '{"zero_rd", mk(32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 1, 0, 0, 2'b00), 5'd0, 0, 0, 0, 0, 32'h0};
    vecs[2] = '{"load",    mk(32'h0000_0080, 32'h0, 32'h0, 5'd5, 1, 1, 0, 2'b01), 5'd5, 1, 1, 0, 1, 32'h1111_2222};
    vecs[3] = '{"store",   mk(32'h0000_0090, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0, 1, 2'b00), 5'd0, 0, 0, 1, 0, 32'h0};
    vecs[4] = '{"link",    mk(32'h0000_7777, 32'h0, 32'h0040_0004, 5'd31, 1, 0, 0, 2'b10), 5'd31, 1, 0, 0, 1,
                LinkEn ? 32'h0040_0008 : 32'h0000_7777};
    vecs[5] = '{"sel11",   mk(32'h0000_5A5A, 32'h0, 32'h0, 5'd12, 1, 0, 0, 2'b11), 5'd12, 1, 0, 0, 1, 32'h0000_5A5A};
    vecs[6] = '{"linkwrap", mk(32'h0000_0010, 32'h0, 32'hFFFF_FFFC, 5'd2, 1, 0, 0, 2'b10), 5'd2, 1, 0, 0, 1,
                LinkEn ? 32'h0000_0000 : 32'h0000_0010};

    // Reset held for two edges with busy EX inputs.
    drive_nop();
    MemReadData = 32'h0;
    Reset = 1'b1;
    drive_ex(mk(32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_1000, 5'd8, 1, 1, 1, 2'b01));
    IFIDRs = 5'd1; IFIDRt = 5'd2; MemReady = 1'b0;
    step(); step();
    check("rst_exmemrd", 32'(EXMEMRd), 32'h0);
    check("rst_exmemrw", 32'(EXMEMRegWrite), 32'h0);
    check("rst_aluout", ALUResult_out, 32'h0);
    check("rst_memaddr", MemAddr, 32'h0);
    check("rst_memrdwr", {30'h0, MemRd, MemWr}, 32'h0);
    check("rst_memwbrd", 32'(MEMWBRd), 32'h0);
    check("rst_memwbrw", 32'(MEMWBRegWrite), 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_stall", 32'(PipeStall), 32'h0);

    Reset = 1'b0;
    drive_nop();
    drive_ex(mk(32'h0000_1234, 32'h0, 32'h0, 5'd8, 1, 0, 0, 2'b00));
    step();
    check("post_exmemrd", 32'(EXMEMRd), 32'd8);
    check("post_aluout", ALUResult_out, 32'h1234);
    check("post_memwbrw0", 32'(MEMWBRegWrite), 32'h0);
    drive_nop();
    step();
    check("post_wdata", WriteData, 32'h1234);
    check("post_memwbrw", 32'(MEMWBRegWrite), 32'h1);
    check("post_memwbrd", 32'(MEMWBRd), 32'd8);

    for (int i = 0; i < 7; i++) begin
      drive_nop();
      drive_ex(vecs[i].in);
      step();
      check({vecs[i].name, "_exmemrd"}, 32'(EXMEMRd), 32'(vecs[i].exp_rd));
      check({vecs[i].name, "_exmemrw"}, 32'(EXMEMRegWrite), 32'(vecs[i].exp_rw));
      check({vecs[i].name, "_memrd"}, 32'(MemRd), 32'(vecs[i].exp_memrd));
      check({vecs[i].name, "_memwr"}, 32'(MemWr), 32'(vecs[i].exp_memwr));
      check({vecs[i].name, "_memaddr"}, MemAddr, vecs[i].in.alu);
      check({vecs[i].name, "_memwdata"}, MemWData, vecs[i].in.store);
      drive_nop();
      MemReadData = 32'h1111_2222;
      step();
      check({vecs[i].name, "_wbrw"}, 32'(MEMWBRegWrite), 32'(vecs[i].exp_wb_rw));
      if (vecs[i].exp_wb_rw) check({vecs[i].name, "_wdata"}, WriteData, vecs[i].exp_wd);
    end

    // Load-use: exactly one stall cycle with a bubble, then the re-presented load goes in.
    drive_nop();
    drive_ex(mk(32'h0000_0100, 32'h0, 32'h0, 5'd9, 1, 1, 0, 2'b01));
    IFIDRt = 5'd9;
    #1 check("lu_stall", 32'(PipeStall), 32'h1);
    step();
    check("lu_bubble_rw", 32'(EXMEMRegWrite), 32'h0);
    check("lu_bubble_memrd", 32'(MemRd), 32'h0);
    check("lu_bubble_alu", ALUResult_out, 32'h0);
    IFIDRt = 5'd0;
    #1 check("lu_stall_clear", 32'(PipeStall), 32'h0);
    step();
    check("lu_memrd", 32'(MemRd), 32'h1);
    check("lu_memaddr", MemAddr, 32'h0000_0100);
    check("lu_exmemrd", 32'(EXMEMRd), 32'd9);

    // Three-cycle memory wait with a Flush pulse in the middle.
    drive_nop();
    drive_ex(mk(32'h0000_0200, 32'h0, 32'h0, 5'd10, 1, 1, 0, 2'b01));
    step();
    drive_ex(mk(32'h0000_0333, 32'h0, 32'h0, 5'd11, 1, 0, 0, 2'b00));
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Flush = (i == 1);
      #1 check("wait_stall", 32'(PipeStall), 32'h1);
      step();
      check("wait_alu_hold", ALUResult_out, 32'h0000_0200);
      check("wait_rd_hold", 32'(EXMEMRd), 32'd10);
      check("wait_memrd", 32'(MemRd), 32'h1);
      check("wait_wb_bubble", 32'(MEMWBRegWrite), 32'h0);
    end
    Flush = 1'b0; MemReady = 1'b1; MemReadData = 32'hCAFE_F00D;
    #1 check("wait_stall_end", 32'(PipeStall), 32'h0);
    step();
    check("wait_wdata", WriteData, 32'hCAFE_F00D);
    check("wait_wbrw", 32'(MEMWBRegWrite), 32'h1);
    check("wait_wbrd", 32'(MEMWBRd), 32'd10);
    check("wait_next_rd", 32'(EXMEMRd), 32'd11);

    // Reset arriving while a store waits aborts the access.
    drive_nop();
    drive_ex(mk(32'h0000_0400, 32'h0000_0055, 32'h0, 5'd0, 0, 0, 1, 2'b00));
    step();
    drive_nop();
    MemReady = 1'b0;
    step();
    check("rstwait_memwr", 32'(MemWr), 32'h1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rstwait_memwr0", 32'(MemWr), 32'h0);
    check("rstwait_memrd0", 32'(MemRd), 32'h0);
    #1 check("rstwait_stall0", 32'(PipeStall), 32'h0);
    drive_nop();
    step();

    // Random traffic against a cycle-level reference model of both pipeline registers.
    m_ex = '0; m_wb_rd = '0; m_wb_rw = 1'b0; m_wb_val = '0;
    Reset = 1'b1;
    step();
    for (int c = 0; c < 600; c++) begin
      Reset        = ($urandom_range(0, 39) == 0);
      ALUResult_in = $urandom;
      ForwardB_out = $urandom;
      PCAddResult2 = $urandom;
      EXRTorRD     = 5'($urandom_range(0, 3));
      RegWrite1    = 1'($urandom_range(0, 1));
      MemRead1     = ($urandom_range(0, 3) == 0);
      MemWrite1    = !MemRead1 && ($urandom_range(0, 3) == 0);
      MemtoReg1    = 2'($urandom_range(0, 3));
      Flush        = ($urandom_range(0, 9) == 0);
      IFIDRs       = 5'($urandom_range(0, 3));
      IFIDRt       = 5'($urandom_range(0, 3));
      MemReady     = ($urandom_range(0, 2) != 0);
      MemReadData  = $urandom;
      #1;
      hold = (m_ex.mr || m_ex.mw) && !MemReady;
      lu   = MemRead1 && RegWrite1 && EXRTorRD != 0 && (EXRTorRD == IFIDRs || EXRTorRD == IFIDRt);
      check("rnd_stall", 32'(PipeStall), 32'(hold || lu));
      nxt = mk(ALUResult_in, ForwardB_out, PCAddResult2, EXRTorRD, RegWrite1 && EXRTorRD != 0,
               MemRead1, MemWrite1, MemtoReg1);
      if (Reset) begin
        m_ex = '0; m_wb_rd = '0; m_wb_rw = 1'b0; m_wb_val = '0;
      end else if (hold) begin
        m_wb_rw = 1'b0;
      end else begin
        m_wb_rd  = m_ex.rd;
        m_wb_rw  = m_ex.rw;
        m_wb_val = ref_wb(m_ex, MemReadData);
        m_ex     = (Flush || lu) ? ex_t'('0) : nxt;
      end
      step();
      check("rnd_exmemrd", 32'(EXMEMRd), 32'(m_ex.rd));
      check("rnd_exmemrw", 32'(EXMEMRegWrite), 32'(m_ex.rw));
      check("rnd_aluout", ALUResult_out, m_ex.alu);
      check("rnd_memwdata", MemWData, m_ex.store);
      check("rnd_memrdwr", {30'h0, MemRd, MemWr}, {30'h0, m_ex.mr, m_ex.mw});
      check("rnd_memwbrw", 32'(MEMWBRegWrite), 32'(m_wb_rw));
      if (m_wb_rw) begin
        check("rnd_memwbrd", 32'(MEMWBRd), 32'(m_wb_rd));
        check("rnd_wdata", WriteData, m_wb_val);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
